ah_cam_gen: RTL and testbench

AH_CAM_GEN -- requirements
Module: ah_cam_gen

---
 rtl/ah_cam_gen.sv | 192 +++++++++++++++++++
 tb/tb_ah_cam_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ah_cam_gen.sv
// ---------------------------------------------------------------------------
// ah_cam_gen -- small content-addressable memory with allocate-on-write and
// snoop (search) with optional invalidate-on-hit.
//
// Writes allocate the lowest free slot. Snoops compare a key against the
// low KWIDTH bits of every valid entry. The lowest matching index wins. The
// response is registered one cycle after the snoop.
//
// Ports
//   clk, rst_an          clock, synchronous active-low reset
//   wr_valid/wr_ready    write handshake (ready = not full)
//   wr_data              entry to store
//   wr_idx               slot the pending write will occupy (0 when full)
//   snp_valid/snp_key    snoop request and search key (no backpressure)
//   snp_inv              clear the matched entry's valid bit on a hit
//   rsp_valid/rsp_hit    registered response strobe and hit flag
//   rsp_data/rsp_idx     matched entry and its index (0 unless a hit is shown)
//   count/full/empty     occupancy
// ---------------------------------------------------------------------------

// One CAM slot: valid bit, stored word, and its key comparator.
module ah_cam_entry #(
    parameter int DWIDTH = 64,
    parameter int KWIDTH = 35
) (
    input  logic              clk,
    input  logic              rst_an,
    input  logic              wr_en_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              inv_en_i,
    input  logic [KWIDTH-1:0] key_i,
    output logic              vld_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              match_o
);
    logic              vld_q, vld_d;
    logic [DWIDTH-1:0] data_q, data_d;

    // The top never selects one slot for both the write and the invalidate.
    // A write targets a free slot and an invalidate targets a valid one.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (wr_en_i) begin
            vld_d  = 1'b1;
            data_d = wr_data_i;
        end else if (inv_en_i) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_an) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o   = vld_q;
    assign data_o  = data_q;
    assign match_o = vld_q && (data_q[KWIDTH-1:0] == key_i);
endmodule

module ah_cam_gen #(
    parameter int DEPTH  = 50,
    parameter int DWIDTH = 64,
    parameter int KWIDTH = 35,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_an,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DWIDTH-1:0] wr_data,
    output logic [AW-1:0]     wr_idx,
    input  logic              snp_valid,
    input  logic [KWIDTH-1:0] snp_key,
    input  logic              snp_inv,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [DWIDTH-1:0] rsp_data,
    output logic [AW-1:0]     rsp_idx,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0]             ent_vld;
    logic [DEPTH-1:0][DWIDTH-1:0] ent_data;
    logic [DEPTH-1:0]             ent_match;
    logic [DEPTH-1:0]             wr_sel, inv_sel;

    logic [DEPTH-1:0]  free_oh, hit_oh;
    logic [AW-1:0]     free_idx, hit_idx;
    logic [DWIDTH-1:0] hit_data;
    logic              hit, wr_acc, inv_acc;

    logic [CW-1:0]     count_q, count_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0]     rsp_idx_q, rsp_idx_d;

    // Lowest free slot and lowest matching slot. The loops run from the top
    // down so the lowest index is written last and wins.
    always_comb begin
        free_oh  = '0;
        free_idx = '0;
        hit_oh   = '0;
        hit_idx  = '0;
        hit_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_vld[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
                free_idx   = AW'(i);
            end
            if (ent_match[i]) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit_idx   = AW'(i);
                hit_data  = ent_data[i];
            end
        end
    end

    assign hit     = |ent_match;
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign wr_acc  = wr_valid && !full;
    assign inv_acc = snp_valid && snp_inv && hit;
    assign wr_sel  = wr_acc  ? free_oh : '0;
    assign inv_sel = inv_acc ? hit_oh  : '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        ah_cam_entry #(
            .DWIDTH (DWIDTH),
            .KWIDTH (KWIDTH)
        ) u_ent (
            .clk       (clk),
            .rst_an    (rst_an),
            .wr_en_i   (wr_sel[g]),
            .wr_data_i (wr_data),
            .inv_en_i  (inv_sel[g]),
            .key_i     (snp_key),
            .vld_o     (ent_vld[g]),
            .data_o    (ent_data[g]),
            .match_o   (ent_match[g])
        );
    end

    // A write and an invalidate in the same cycle cancel. A write only
    // happens when not full, and an invalidate needs a valid entry. So count
    // stays within 0..DEPTH.
    always_comb begin
        count_d     = count_q + CW'(wr_acc) - CW'(inv_acc);
        rsp_valid_d = snp_valid;
        rsp_hit_d   = snp_valid && hit;
        rsp_data_d  = (snp_valid && hit) ? hit_data : '0;
        rsp_idx_d   = (snp_valid && hit) ? hit_idx  : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_an) begin
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_idx_q   <= '0;
        end else begin
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_data_q  <= rsp_data_d;
            rsp_idx_q   <= rsp_idx_d;
        end
    end

    // When full, no slot is free and free_idx stays at its default of 0.
    assign wr_ready  = !full;
    assign wr_idx    = free_idx;
    assign count     = count_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_idx   = rsp_idx_q;
endmodule

// File: tb/tb_ah_cam_gen.sv
// Directed bench for ah_cam_gen with DEPTH=4, DWIDTH=16, KWIDTH=8.
module tb_ah_cam_gen;
    localparam int DEPTH = 4, DWIDTH = 16, KWIDTH = 8;
    localparam int AW = 2, CW = 3;

    logic              clk = 1'b0;
    logic              rst_an;
    logic              wr_valid;
    logic              wr_ready;
    logic [DWIDTH-1:0] wr_data;
    logic [AW-1:0]     wr_idx;
    logic              snp_valid;
    logic [KWIDTH-1:0] snp_key;
    logic              snp_inv;
    logic              rsp_valid, rsp_hit;
    logic [DWIDTH-1:0] rsp_data;
    logic [AW-1:0]     rsp_idx;
    logic [CW-1:0]     count;
    logic              full, empty;

    int checks = 0;
    int errors = 0;

    ah_cam_gen #(.DEPTH(DEPTH), .DWIDTH(DWIDTH), .KWIDTH(KWIDTH)) dut (
        .clk(clk), .rst_an(rst_an),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_idx(wr_idx),
        .snp_valid(snp_valid), .snp_key(snp_key), .snp_inv(snp_inv),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data), .rsp_idx(rsp_idx),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_valid = 1'b0; wr_data = '0; snp_valid = 1'b0; snp_key = '0; snp_inv = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},    32'(count),     32'd0);
        chk({tag, "_empty"},    32'(empty),     32'd1);
        chk({tag, "_full"},     32'(full),      32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready),  32'd1);
        chk({tag, "_wr_idx"},   32'(wr_idx),    32'd0);
        chk({tag, "_rsp_valid"},32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_hit"},  32'(rsp_hit),   32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data),  32'd0);
        chk({tag, "_rsp_idx"},  32'(rsp_idx),   32'd0);
    endtask

    // One write, checking the slot it is offered beforehand.
    task automatic do_write(input logic [15:0] d, input int exp_idx, input string tag);
        chk({tag, "_wr_idx"}, 32'(wr_idx), 32'(exp_idx));
        wr_valid = 1'b1; wr_data = d;
        step();
        idle();
    endtask

    // One snoop, checking the registered response on the next cycle.
    task automatic do_snoop(input logic [7:0] k, input logic inv, input logic exp_hit,
                            input int exp_idx, input logic [15:0] exp_data, input string tag);
        snp_valid = 1'b1; snp_key = k; snp_inv = inv;
        step();
        idle();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_hit"},   32'(rsp_hit),   32'(exp_hit));
        chk({tag, "_rsp_idx"},   32'(rsp_idx),   32'(exp_idx));
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'(exp_data));
    endtask

    initial begin
        idle();
        rst_an = 1'b0;
        step(); step();
        chk_reset_state("rst");
        rst_an = 1'b1;

        // Fill the CAM.
        do_write(16'h1111, 0, "fill0");
        do_write(16'h2222, 1, "fill1");
        do_write(16'h3333, 2, "fill2");
        do_write(16'h4444, 3, "fill3");
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        chk("fill_wr_idx_full", 32'(wr_idx), 32'd0);
        chk("fill_empty", 32'(empty), 32'd0);
        // A fifth write while full is dropped.
        wr_valid = 1'b1; wr_data = 16'h7777;
        step(); idle();
        chk("w5_count", 32'(count), 32'd4);
        do_snoop(8'h77, 1'b0, 1'b0, 0, 16'h0000, "w5_miss");

        // Hit without invalidate. The strobe lasts one cycle, then the response drops to zero.
        do_snoop(8'h33, 1'b0, 1'b1, 2, 16'h3333, "hit33");
        chk("hit33_count", 32'(count), 32'd4);
        step();
        chk("pulse_valid", 32'(rsp_valid), 32'd0);
        chk("pulse_hit", 32'(rsp_hit), 32'd0);
        chk("pulse_data", 32'(rsp_data), 32'd0);
        chk("pulse_idx", 32'(rsp_idx), 32'd0);

        // Invalidate and reuse.
        do_snoop(8'h22, 1'b1, 1'b1, 1, 16'h2222, "inv22");
        chk("inv22_count", 32'(count), 32'd3);
        chk("inv22_full", 32'(full), 32'd0);
        do_write(16'h5555, 1, "reuse");
        chk("reuse_count", 32'(count), 32'd4);
        do_snoop(8'h55, 1'b0, 1'b1, 1, 16'h5555, "hit55");

        // Full: a write and an invalidating hit in the same cycle. The write is dropped.
        wr_valid = 1'b1; wr_data = 16'h6666;
        snp_valid = 1'b1; snp_key = 8'h33; snp_inv = 1'b1;
        step(); idle();
        chk("sim_rsp_hit", 32'(rsp_hit), 32'd1);
        chk("sim_rsp_idx", 32'(rsp_idx), 32'd2);
        chk("sim_count", 32'(count), 32'd3);
        chk("sim_wr_idx", 32'(wr_idx), 32'd2);
        do_snoop(8'h66, 1'b0, 1'b0, 0, 16'h0000, "sim_dropped");

        // Duplicate keys: the lowest index wins.
        rst_an = 1'b0; step(); rst_an = 1'b1;
        do_write(16'hA177, 0, "dup0");
        do_write(16'h1001, 1, "dup1");
        do_write(16'h2002, 2, "dup2");
        do_write(16'hB077, 3, "dup3");
        do_snoop(8'h77, 1'b0, 1'b1, 0, 16'hA177, "dup_lo");
        do_snoop(8'h77, 1'b1, 1'b1, 0, 16'hA177, "dup_inv");
        chk("dup_inv_count", 32'(count), 32'd3);
        do_snoop(8'h77, 1'b0, 1'b1, 3, 16'hB077, "dup_next");

        // A snoop does not see a write made in the same cycle.
        rst_an = 1'b0; step(); rst_an = 1'b1;
        wr_valid = 1'b1; wr_data = 16'h0099;
        snp_valid = 1'b1; snp_key = 8'h99; snp_inv = 1'b0;
        step(); idle();
        chk("same_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("same_rsp_hit", 32'(rsp_hit), 32'd0);
        chk("same_count", 32'(count), 32'd1);
        do_snoop(8'h99, 1'b0, 1'b1, 0, 16'h0099, "same_repeat");
        // snp_inv is ignored on a miss, and when no snoop is valid.
        do_snoop(8'h55, 1'b1, 1'b0, 0, 16'h0000, "inv_miss");
        chk("inv_miss_count", 32'(count), 32'd1);
        snp_valid = 1'b0; snp_key = 8'h99; snp_inv = 1'b1;
        step(); idle();
        chk("inv_novalid_count", 32'(count), 32'd1);
        chk("inv_novalid_rsp", 32'(rsp_valid), 32'd0);

        // Reset mid-stream discards the in-flight snoop and the pending write.
        wr_valid = 1'b1; wr_data = 16'h1234;
        snp_valid = 1'b1; snp_key = 8'h99; snp_inv = 1'b0;
        rst_an = 1'b0;
        step();
        chk_reset_state("midrst");
        rst_an = 1'b1; idle();
        step();
        chk("post_rst_count", 32'(count), 32'd0);
        do_snoop(8'h99, 1'b0, 1'b0, 0, 16'h0000, "post_rst_miss");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
